operand_loader: RTL

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/hack_pkg.sv | 6 +
 rtl/word_assembler.sv | 27 ++
 rtl/operand_loader.sv | 65 ++++++
 3 files changed

// File: rtl/hack_pkg.sv
// hack_pkg: shared widths and loader state encoding
package hack_pkg;
    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;
    typedef enum logic [2:0] {A_0, A_1, B_0, B_1, PRESENT} state_e;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: writes one byte into the low or high half of a word register, with clear
module word_assembler
    import hack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic              hi_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o
);
    logic [WORD_W-1:0] word_q, word_d;
    // merge the incoming byte into the selected half, other half kept
    always_comb begin
        word_d = clr_i ? '0 :
                 !we_i ? word_q :
                 hi_i  ? {byte_i, word_q[BYTE_W-1:0]} :
                         {word_q[WORD_W-1:BYTE_W], byte_i};
    end
    // word register, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) word_q <= '0;
        else     word_q <= word_d;
    end
    assign word_o = word_q;
endmodule

// File: rtl/operand_loader.sv
// operand_loader: assembles two 16-bit operands from a byte stream and presents them as a pair
module operand_loader
    import hack_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] a,
    output logic [WORD_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready
);
    state_e state_q, state_d;
    logic   accept, second, hi_sel, we_a, we_b;
    assign in_ready  = state_q != PRESENT;
    assign out_valid = state_q == PRESENT;
    assign accept    = in_valid && in_ready && !abort;
    assign second    = (state_q == A_1) || (state_q == B_1);
    assign hi_sel    = second == LSB_FIRST;
    assign we_a      = accept && ((state_q == A_0) || (state_q == A_1));
    assign we_b      = accept && ((state_q == B_0) || (state_q == B_1));
    // next state: abort wins, then one step per accepted byte or consumed pair
    always_comb begin
        state_d = state_q;
        if (abort) state_d = A_0;
        else begin
            case (state_q)
                A_0:     state_d = in_valid  ? A_1     : A_0;
                A_1:     state_d = in_valid  ? B_0     : A_1;
                B_0:     state_d = in_valid  ? B_1     : B_0;
                B_1:     state_d = in_valid  ? PRESENT : B_1;
                PRESENT: state_d = out_ready ? A_0     : PRESENT;
                default: state_d = A_0;
            endcase
        end
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= A_0;
        else     state_q <= state_d;
    end
    word_assembler u_a (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (abort),
        .we_i   (we_a),
        .hi_i   (hi_sel),
        .byte_i (in_data),
        .word_o (a)
    );
    word_assembler u_b (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (abort),
        .we_i   (we_b),
        .hi_i   (hi_sel),
        .byte_i (in_data),
        .word_o (b)
    );
endmodule
